// File: rtl/fg_cordic_seq.sv
// Sequencer for the pipelined CORDIC sine/cosine datapath: NCO phase accumulator,
// sample-rate prescaler, valid-token tracking through the pipeline and drain on stop.
module fg_cordic_seq #(
    parameter int BITWIDTH       = 8,
    parameter int BITWIDTH_PHASE = 10,
    parameter int PRESCALE_W     = 16,
    parameter int BURST_W        = 12
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic                      burst_mode_i,
    input  logic [BURST_W-1:0]        burst_len_i,
    input  logic [PRESCALE_W-1:0]     prescale_i,
    input  logic [BITWIDTH_PHASE-1:0] phase_inc_i,
    input  logic [BITWIDTH_PHASE-1:0] phase_offset_i,
    input  logic [BITWIDTH-1:0]       amplitude_i,
    input  logic [BITWIDTH:0]         cordic_cos_i,
    input  logic [BITWIDTH:0]         cordic_sin_i,
    output logic                      cordic_clk_en_o,
    output logic [BITWIDTH_PHASE-1:0] cordic_phase_o,
    output logic [BITWIDTH-1:0]       cordic_x_o,
    output logic [BITWIDTH-1:0]       cordic_y_o,
    output logic [BITWIDTH:0]         cos_o,
    output logic [BITWIDTH:0]         sin_o,
    output logic                      sample_valid_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int DW = (BITWIDTH > 2) ? $clog2(BITWIDTH) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(BITWIDTH - 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [BITWIDTH_PHASE-1:0] phase_acc_q, phase_acc_d;
    logic [PRESCALE_W-1:0]     pcount_q, pcount_d;
    logic [PRESCALE_W-1:0]     prescale_q, prescale_d;
    logic [BURST_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic [BURST_W-1:0]        burst_len_q, burst_len_d;
    logic                      burst_mode_q, burst_mode_d;
    logic [DW-1:0]             drain_cnt_q, drain_cnt_d;
    logic [BITWIDTH-1:0]       valid_sr_q, valid_sr_d;
    logic                      en_q, en_d;
    logic [BITWIDTH:0]         cos_q, cos_d;
    logic [BITWIDTH:0]         sin_q, sin_d;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;
    logic                      tick;
    logic                      en;

    always_comb begin
        state_d      = state_q;
        phase_acc_d  = phase_acc_q;
        pcount_d     = pcount_q;
        prescale_d   = prescale_q;
        burst_cnt_d  = burst_cnt_q;
        burst_len_d  = burst_len_q;
        burst_mode_d = burst_mode_q;
        drain_cnt_d  = drain_cnt_q;
        done_d       = 1'b0;
        tick         = 1'b0;
        en           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !(burst_mode_i && (burst_len_i == '0))) begin
                    state_d      = S_RUN;
                    burst_mode_d = burst_mode_i;
                    burst_len_d  = burst_len_i;
                    prescale_d   = prescale_i;
                    phase_acc_d  = '0;
                    pcount_d     = '0;
                    burst_cnt_d  = '0;
                end
            end
            S_RUN: begin
                tick = (pcount_q == prescale_q);
                if (tick) begin
                    en          = 1'b1;
                    pcount_d    = '0;
                    phase_acc_d = phase_acc_q + phase_inc_i;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end else begin
                    pcount_d = pcount_q + 1'b1;
                end
                if (stop_i || (tick && burst_mode_q && (burst_cnt_d == burst_len_q))) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                en = 1'b1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A token at the pipeline tail is captured only right after the enable that
    // moved it there, so a token parked at the tail is never counted twice.
    always_comb begin
        valid_sr_d = valid_sr_q;
        cos_d      = cos_q;
        sin_d      = sin_q;
        en_d       = en;
        valid_d    = valid_sr_q[BITWIDTH-1] && en_q;
        if (en) begin
            valid_sr_d = {valid_sr_q[BITWIDTH-2:0], tick};
        end
        if (valid_d) begin
            cos_d = cordic_cos_i;
            sin_d = cordic_sin_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            phase_acc_q  <= '0;
            pcount_q     <= '0;
            prescale_q   <= '0;
            burst_cnt_q  <= '0;
            burst_len_q  <= '0;
            burst_mode_q <= 1'b0;
            drain_cnt_q  <= '0;
            valid_sr_q   <= '0;
            en_q         <= 1'b0;
            cos_q        <= '0;
            sin_q        <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_acc_q  <= phase_acc_d;
            pcount_q     <= pcount_d;
            prescale_q   <= prescale_d;
            burst_cnt_q  <= burst_cnt_d;
            burst_len_q  <= burst_len_d;
            burst_mode_q <= burst_mode_d;
            drain_cnt_q  <= drain_cnt_d;
            valid_sr_q   <= valid_sr_d;
            en_q         <= en_d;
            cos_q        <= cos_d;
            sin_q        <= sin_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
        end
    end

    assign cordic_clk_en_o = en;
    assign cordic_phase_o  = phase_acc_q + phase_offset_i;
    assign cordic_x_o      = amplitude_i;
    assign cordic_y_o      = '0;
    assign cos_o           = cos_q;
    assign sin_o           = sin_q;
    assign sample_valid_o  = valid_q;
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_q;

endmodule

// File: tb/tb_fg_cordic_seq.sv
// Scoreboard bench for fg_cordic_seq with a behavioural 8-stage CORDIC stand-in;
// expected samples, enables, busy and done timing come from a run-level model.
`timescale 1ns/1ps
module tb_fg_cordic_seq;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        start_i, stop_i, burst_mode_i;
    logic [11:0] burst_len_i;
    logic [15:0] prescale_i;
    logic [9:0]  phase_inc_i, phase_offset_i;
    logic [7:0]  amplitude_i;
    logic [8:0]  cordic_cos_i, cordic_sin_i;
    logic        cordic_clk_en_o;
    logic [9:0]  cordic_phase_o;
    logic [7:0]  cordic_x_o, cordic_y_o;
    logic [8:0]  cos_o, sin_o;
    logic        sample_valid_o, busy_o, done_o;

    fg_cordic_seq #(.BITWIDTH(8), .BITWIDTH_PHASE(10), .PRESCALE_W(16), .BURST_W(12)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i),
        .burst_mode_i(burst_mode_i), .burst_len_i(burst_len_i), .prescale_i(prescale_i),
        .phase_inc_i(phase_inc_i), .phase_offset_i(phase_offset_i), .amplitude_i(amplitude_i),
        .cordic_cos_i(cordic_cos_i), .cordic_sin_i(cordic_sin_i),
        .cordic_clk_en_o(cordic_clk_en_o), .cordic_phase_o(cordic_phase_o),
        .cordic_x_o(cordic_x_o), .cordic_y_o(cordic_y_o), .cos_o(cos_o), .sin_o(sin_o),
        .sample_valid_o(sample_valid_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int cur_amp = 0;

    typedef struct {int cyc; int c; int s;} smp_t;
    smp_t exp_q[$];
    int   done_q[$];
    bit   en_exp[int];
    bit   busy_exp[int];
    int   ph_exp[int];

    function automatic int cordic_f(int ph, int amp, bit want_sin);
        real th, v;
        th = 2.0 * 3.14159265358979 * real'(ph) / 1024.0;
        v  = real'(amp) * 1.646760258 * (want_sin ? $sin(th) : $cos(th));
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    // Stand-in CORDIC: 8 enabled register stages, ideal math with CORDIC gain.
    logic signed [8:0] pc [8] = '{default: 9'sd0};
    logic signed [8:0] ps [8] = '{default: 9'sd0};
    always @(posedge clk_i) begin
        if (cordic_clk_en_o) begin
            for (int i = 7; i > 0; i--) begin
                pc[i] <= pc[i-1];
                ps[i] <= ps[i-1];
            end
            pc[0] <= 9'(cordic_f(int'(cordic_phase_o), int'($signed(cordic_x_o)), 1'b0));
            ps[0] <= 9'(cordic_f(int'(cordic_phase_o), int'($signed(cordic_x_o)), 1'b1));
        end
    end
    assign cordic_cos_i = pc[7];
    assign cordic_sin_i = ps[7];

    // Monitor: compares every cycle against the model's expectations.
    initial begin
        smp_t h;
        forever begin
            @(posedge clk_i);
            #2;
            if (rstn_i) begin
                chk("clk_en", int'(cordic_clk_en_o), int'(en_exp.exists(cyc)));
                chk("busy", int'(busy_o), int'(busy_exp.exists(cyc)));
                if (ph_exp.exists(cyc)) begin
                    chk("phase", int'(cordic_phase_o), ph_exp[cyc]);
                    chk("x_amp", int'($signed(cordic_x_o)), cur_amp);
                    chk("y_zero", int'(cordic_y_o), 0);
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    checks++; errors++;
                    $display("FAIL missed_sample: expected at cyc %0d, still absent at %0d", exp_q[0].cyc, cyc);
                    void'(exp_q.pop_front());
                end
                if (sample_valid_o) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_sample @cyc %0d: got cos %0d sin %0d, expected none", cyc, $signed(cos_o), $signed(sin_o));
                    end else begin
                        h = exp_q.pop_front();
                        chk("sample_cycle", cyc, h.cyc);
                        chk("cos", int'($signed(cos_o)), h.c);
                        chk("sin", int'($signed(sin_o)), h.s);
                    end
                end
                while (done_q.size() > 0 && done_q[0] < cyc) begin
                    checks++; errors++;
                    $display("FAIL missed_done: expected at cyc %0d, still absent at %0d", done_q[0], cyc);
                    void'(done_q.pop_front());
                end
                if (done_o) begin
                    if (done_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_done @cyc %0d: got 1 expected 0", cyc);
                    end else begin
                        chk("done_cycle", cyc, done_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        chk({tag, "_cos"}, int'(cos_o), 0);
        chk({tag, "_sin"}, int'(sin_o), 0);
        chk({tag, "_valid"}, int'(sample_valid_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_clk_en"}, int'(cordic_clk_en_o), 0);
    endtask

    // Called at #1 inside a cycle. Builds the run's expectations, then drives it.
    // stop_rel/abort_rel are cycles after RUN entry (-1 = none).
    task automatic do_run(bit mode, int len, int p, int inc, int off, int amp,
                          int stop_rel, bit poke, int abort_rel);
        int r0, s, endc, t, k;
        int e[$];
        int ph[$];
        r0   = cyc + 1;
        s    = (stop_rel >= 0) ? r0 + stop_rel : 32'h7fffffff;
        k    = 0;
        endc = 0;
        forever begin
            t = r0 + p + k * (p + 1);
            if (t > s) begin endc = s; break; end
            e.push_back(t);
            ph.push_back((off + k * inc) % 1024);
            en_exp[t] = 1'b1;
            ph_exp[t] = ph[k];
            k++;
            if (mode && k == len) begin endc = t; break; end
        end
        for (int d = 1; d <= 7; d++) begin
            e.push_back(endc + d);
            en_exp[endc + d] = 1'b1;
        end
        for (int c = r0; c <= endc + 7; c++) busy_exp[c] = 1'b1;
        done_q.push_back(endc + 8);
        for (int i = 0; i < ph.size(); i++)
            exp_q.push_back('{cyc: e[i+7] + 2, c: cordic_f(ph[i], amp, 1'b0), s: cordic_f(ph[i], amp, 1'b1)});
        cur_amp = amp;

        burst_mode_i   = mode;
        burst_len_i    = 12'(len);
        prescale_i     = 16'(p);
        phase_inc_i    = 10'(inc);
        phase_offset_i = 10'(off);
        amplitude_i    = 8'(amp);
        start_i        = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        if (poke) begin
            prescale_i   = 16'(p + 5);
            burst_mode_i = ~mode;
            burst_len_i  = 12'd1;
        end
        while (cyc < endc + 12) begin
            if (abort_rel >= 0 && cyc == r0 + abort_rel) begin
                chk("pre_reset_cos_nonzero", int'(cos_o != '0), 1);
                rstn_i = 1'b0;
                exp_q.delete(); done_q.delete();
                en_exp.delete(); busy_exp.delete(); ph_exp.delete();
                #1;
                check_reset_outputs("abort");
                repeat (3) @(posedge clk_i);
                #1;
                stop_i  = 1'b0;
                start_i = 1'b0;
                rstn_i  = 1'b1;
                repeat (20) @(posedge clk_i);
                #1;
                return;
            end
            stop_i  = (cyc == s);
            start_i = poke && (cyc >= r0 + 2) && (cyc <= r0 + 4);
            @(posedge clk_i); #1;
        end
        stop_i  = 1'b0;
        start_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int m, len, p, sr;
        rstn_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; burst_mode_i = 1'b0;
        burst_len_i = '0; prescale_i = '0; phase_inc_i = '0; phase_offset_i = '0; amplitude_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rstn_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // continuous, P=0, phase walks 0,64,...,960 and wraps
        do_run(1'b0, 0, 0, 64, 0, 100, 19, 1'b0, -1);
        // burst of 5, P=2
        do_run(1'b1, 5, 2, 100, 30, -77, -1, 1'b0, -1);
        // stop coincides with tick k=5 at P=3
        do_run(1'b0, 0, 3, 200, 900, 90, 3 + 4 * 5, 1'b0, -1);
        // start/prescale/mode changes mid-run are ignored
        do_run(1'b0, 0, 1, 37, 500, 60, 25, 1'b1, -1);

        // burst start with length 0 is ignored
        burst_mode_i = 1'b1; burst_len_i = '0; prescale_i = 16'd2; start_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;

        // quarter-turn offset: cos ~ 0, sin ~ gain*100
        do_run(1'b1, 1, 0, 0, 256, 100, -1, 1'b0, -1);
        chk("quarter_cos_small", int'($signed(cos_o) <= 3 && $signed(cos_o) >= -3), 1);
        chk("quarter_sin_gain", int'($signed(sin_o) >= 161 && $signed(sin_o) <= 167), 1);

        // reset in the middle of a P=3 run
        do_run(1'b0, 0, 3, 16, 0, 100, 200, 1'b0, 60);

        for (int n = 0; n < 6; n++) begin
            m   = int'($urandom_range(0, 1));
            p   = int'($urandom_range(0, 3));
            len = int'($urandom_range(1, 6));
            sr  = (m == 1 && $urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 30));
            do_run(m[0], len, p, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 255)) - 128, sr, $urandom_range(0, 1) == 1, -1);
        end

        repeat (5) @(posedge clk_i);
        #3;
        chk("sample_queue_empty", exp_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
